step_run_ctrl: RTL and testbench

- Run/halt/single-step controller for the single-cycle core.
- Produces `core_en`, which gates PC update, register-file write and data-memory write in the datapath.
- Accepts host commands over a valid/ready port and halts on a PC breakpoint or an EBREAK fetch.
- Counts retired instructions.

---
 rtl/step_run_ctrl_if.sv | 12 +
 rtl/step_run_ctrl.sv | 146 ++++++++++++++
 tb/tb_step_run_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/step_run_ctrl_if.sv
// Host command port of the run/halt/step controller: one command per accepted valid/ready beat.
interface step_run_ctrl_if #(
    parameter int CNT_W = 32
) ();
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [CNT_W-1:0] cmd_arg;

    modport master (output cmd_valid, output cmd_op, output cmd_arg, input  cmd_ready);
    modport slave  (input  cmd_valid, input  cmd_op, input  cmd_arg, output cmd_ready);
endinterface

// File: rtl/step_run_ctrl.sv
// Run/halt/single-step controller for the single-cycle core: gates datapath commit,
// halts on PC breakpoint or EBREAK fetch, and counts retired instructions.
//
// state  | meaning
// S_HALT | core frozen, waiting for RUN or STEP
// S_RUN  | free running until breakpoint, EBREAK or host HALT
// S_STEP | running until step_rem instructions have committed
module step_run_ctrl #(
    parameter int PC_W  = 9,
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    step_run_ctrl_if.slave       cmd,
    input  logic [PC_W-1:0]      pc_cur,
    input  logic [31:0]          instr,
    output logic                 core_en,
    output logic                 halted,
    output logic [2:0]           halt_cause,
    output logic                 halt_evt,
    output logic [CNT_W-1:0]     retired_cnt
);
    typedef enum logic [1:0] {S_HALT, S_RUN, S_STEP} state_t;

    localparam logic [2:0] OP_RUN     = 3'd0;
    localparam logic [2:0] OP_HALT    = 3'd1;
    localparam logic [2:0] OP_STEP    = 3'd2;
    localparam logic [2:0] OP_SET_BP  = 3'd3;
    localparam logic [2:0] OP_CLR_BP  = 3'd4;
    localparam logic [2:0] OP_CLR_CNT = 3'd5;

    localparam logic [2:0] CAUSE_HOST = 3'd1;
    localparam logic [2:0] CAUSE_BP   = 3'd2;
    localparam logic [2:0] CAUSE_EB   = 3'd3;
    localparam logic [2:0] CAUSE_STEP = 3'd4;

    localparam logic [31:0] EBREAK = 32'h0010_0073;

    state_t           state_q, state_d;
    logic [2:0]       cause_q, cause_d;
    logic [CNT_W-1:0] step_q, step_d;
    logic             skip_q, skip_d;
    logic             bp_valid_q;
    logic [PC_W-1:0]  bp_addr_q;
    logic             evt_q;
    logic [CNT_W-1:0] cnt_q;

    logic cmd_acc;
    logic hit_bp;
    logic hit_eb;

    assign cmd_acc = cmd.cmd_valid & cmd.cmd_ready;
    // skip masks both halt sources so the resume instruction always executes
    assign hit_bp  = bp_valid_q & (pc_cur == bp_addr_q) & ~skip_q;
    assign hit_eb  = (instr == EBREAK) & ~skip_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_HALT;
            cause_q    <= 3'd0;
            step_q     <= '0;
            skip_q     <= 1'b0;
            evt_q      <= 1'b0;
            bp_valid_q <= 1'b0;
            bp_addr_q  <= '0;
            cnt_q      <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            step_q  <= step_d;
            skip_q  <= skip_d;
            evt_q   <= (state_q != S_HALT) && (state_d == S_HALT);
            if (cmd_acc && cmd.cmd_op == OP_SET_BP) begin
                bp_addr_q  <= cmd.cmd_arg[PC_W-1:0];
                bp_valid_q <= 1'b1;
            end else if (cmd_acc && cmd.cmd_op == OP_CLR_BP) begin
                bp_valid_q <= 1'b0;
            end
            if (cmd_acc && cmd.cmd_op == OP_CLR_CNT)
                cnt_q <= '0;
            else if (core_en && !(&cnt_q))
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        step_d  = step_q;
        skip_d  = skip_q;
        if (core_en)
            skip_d = 1'b0;
        case (state_q)
            S_HALT: begin
                if (cmd_acc && cmd.cmd_op == OP_RUN) begin
                    state_d = S_RUN;
                    skip_d  = 1'b1;
                end else if (cmd_acc && cmd.cmd_op == OP_STEP) begin
                    state_d = S_STEP;
                    skip_d  = 1'b1;
                    step_d  = (cmd.cmd_arg == '0) ? CNT_W'(1) : cmd.cmd_arg;
                end
            end
            S_RUN: begin
                if (hit_bp) begin
                    state_d = S_HALT;
                    cause_d = CAUSE_BP;
                end else if (hit_eb) begin
                    state_d = S_HALT;
                    cause_d = CAUSE_EB;
                end else if (cmd_acc && cmd.cmd_op == OP_HALT) begin
                    state_d = S_HALT;
                    cause_d = CAUSE_HOST;
                end
            end
            S_STEP: begin
                if (hit_bp) begin
                    state_d = S_HALT;
                    cause_d = CAUSE_BP;
                end else if (hit_eb) begin
                    state_d = S_HALT;
                    cause_d = CAUSE_EB;
                end else begin
                    step_d = step_q - CNT_W'(1);
                    if (step_q == CNT_W'(1)) begin
                        state_d = S_HALT;
                        cause_d = CAUSE_STEP;
                    end else if (cmd_acc && cmd.cmd_op == OP_HALT) begin
                        state_d = S_HALT;
                        cause_d = CAUSE_HOST;
                    end
                end
            end
            default: state_d = S_HALT;
        endcase
    end

    always_comb begin
        cmd.cmd_ready = rst;
        core_en       = (state_q != S_HALT) & ~hit_bp & ~hit_eb;
        halted        = (state_q == S_HALT);
        halt_cause    = cause_q;
        halt_evt      = evt_q;
        retired_cnt   = cnt_q;
    end
endmodule

// File: tb/tb_step_run_ctrl.sv
// Scoreboard bench for step_run_ctrl: each expected halt (cause, count, PC) is queued
// when stimulus is issued and checked by a monitor on every halt_evt pulse.
module tb_step_run_ctrl;
    localparam int PC_W  = 9;
    localparam int CNT_W = 32;

    localparam logic [2:0] OP_RUN = 3'd0, OP_HALT = 3'd1, OP_STEP = 3'd2, OP_SET_BP = 3'd3,
                           OP_CLR_BP = 3'd4, OP_CLR_CNT = 3'd5, OP_RSVD = 3'd6;

    typedef struct {
        logic [2:0]       cause;
        logic [CNT_W-1:0] cnt;
        logic [PC_W-1:0]  pc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [PC_W-1:0]  pc_cur;
    logic [31:0]      instr;
    logic             core_en, halted, halt_evt;
    logic [2:0]       halt_cause;
    logic [CNT_W-1:0] retired_cnt;

    logic             pc_load;
    logic [PC_W-1:0]  pc_load_val;
    logic             eb_en;
    logic [PC_W-1:0]  eb_addr;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    step_run_ctrl_if #(.CNT_W(CNT_W)) bus ();

    step_run_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd         (bus),
        .pc_cur      (pc_cur),
        .instr       (instr),
        .core_en     (core_en),
        .halted      (halted),
        .halt_cause  (halt_cause),
        .halt_evt    (halt_evt),
        .retired_cnt (retired_cnt)
    );

    always #5 clk = ~clk;

    // minimal datapath: PC advances only on committed cycles
    always @(posedge clk) begin
        if (pc_load)
            pc_cur <= pc_load_val;
        else if (core_en)
            pc_cur <= pc_cur + 9'd1;
    end

    assign instr = (eb_en && pc_cur == eb_addr) ? 32'h0010_0073 : 32'h0000_0013;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1 && halt_evt === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_halt_evt", 32'(halt_evt), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("halt_cause", 32'(halt_cause), 32'(e.cause));
                chk("halt_retired_cnt", retired_cnt, e.cnt);
                chk("halt_pc", 32'(pc_cur), 32'(e.pc));
                chk("halt_halted", 32'(halted), 32'd1);
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [CNT_W-1:0] arg);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_arg   = arg;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'd0;
        bus.cmd_arg   = '0;
    endtask

    task automatic expect_halt(input logic [2:0] cause, input logic [CNT_W-1:0] cnt,
                               input logic [PC_W-1:0] pc);
        exp_t e;
        e.cause = cause;
        e.cnt   = cnt;
        e.pc    = pc;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        chk({name, "_pending"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic load_pc(input logic [PC_W-1:0] v);
        @(negedge clk);
        pc_load     = 1'b1;
        pc_load_val = v;
        @(posedge clk);
        #1;
        pc_load = 1'b0;
    endtask

    initial begin
        rst           = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'd0;
        bus.cmd_arg   = '0;
        pc_load       = 1'b1;
        pc_load_val   = '0;
        eb_en         = 1'b0;
        eb_addr       = 9'h018;

        #3;
        chk("rst_core_en", 32'(core_en), 32'd0);
        chk("rst_halted", 32'(halted), 32'd1);
        chk("rst_cause", 32'(halt_cause), 32'd0);
        chk("rst_evt", 32'(halt_evt), 32'd0);
        chk("rst_cnt", retired_cnt, 32'd0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst     = 1'b1;
        pc_load = 1'b0;
        #1;
        chk("cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("idle_core_en", 32'(core_en), 32'd0);

        // run for exactly ten commits, then host halt
        send(OP_RUN, '0);
        chk("run_core_en", 32'(core_en), 32'd1);
        repeat (9) @(posedge clk);
        expect_halt(3'd1, 32'd10, 9'h00a);
        send(OP_HALT, '0);
        wait_idle("run_halt");

        send(OP_CLR_CNT, '0);
        chk("clr_cnt_halted", retired_cnt, 32'd0);
        expect_halt(3'd4, 32'd3, 9'h00d);
        send(OP_STEP, 32'd3);
        wait_idle("step3");
        expect_halt(3'd4, 32'd4, 9'h00e);
        send(OP_STEP, 32'd0);
        wait_idle("step0");

        send(OP_HALT, '0);
        send(OP_RSVD, 32'hffff_ffff);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("halt_in_halt_cause", 32'(halt_cause), 32'd4);
        chk("halt_in_halt_state", 32'(halted), 32'd1);

        // breakpoint at 0x010, resume past it, then a later breakpoint
        load_pc(9'h000);
        send(OP_SET_BP, 32'h0000_0010);
        expect_halt(3'd2, 32'd20, 9'h010);
        send(OP_RUN, '0);
        wait_idle("bp_hit");
        expect_halt(3'd2, 32'd24, 9'h014);
        send(OP_RUN, '0);
        send(OP_SET_BP, 32'h0000_0014);
        wait_idle("bp_resume");

        eb_en = 1'b1;
        expect_halt(3'd3, 32'd28, 9'h018);
        send(OP_RUN, '0);
        wait_idle("ebreak");
        eb_en = 1'b0;

        // host HALT lands in the same cycle as the breakpoint hit
        send(OP_SET_BP, 32'h0000_0020);
        expect_halt(3'd2, 32'd36, 9'h020);
        send(OP_RUN, '0);
        repeat (8) @(posedge clk);
        send(OP_HALT, '0);
        wait_idle("bp_vs_host");

        send(OP_CLR_BP, '0);
        send(OP_RUN, '0);
        send(OP_CLR_CNT, '0);
        chk("clr_cnt_commit", retired_cnt, 32'd0);
        expect_halt(3'd1, 32'd1, 9'h022);
        send(OP_HALT, '0);
        wait_idle("clr_cnt_run");

        // async reset in the middle of a long step must wipe the breakpoint too
        send(OP_SET_BP, 32'h0000_0100);
        send(OP_STEP, 32'd100);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("step_core_en", 32'(core_en), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_core_en", 32'(core_en), 32'd0);
        chk("arst_halted", 32'(halted), 32'd1);
        chk("arst_cnt", retired_cnt, 32'd0);
        chk("arst_cause", 32'(halt_cause), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        load_pc(9'h100);
        expect_halt(3'd1, 32'd3, 9'h103);
        send(OP_RUN, '0);
        repeat (2) @(posedge clk);
        send(OP_HALT, '0);
        wait_idle("arst_bp_lost");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
